// File: rtl/linebuf_port_sched.sv
// linebuf_port_sched: read-priority scheduler for the ping-pong line RAM.
// Define LINEBUF_STATS_EN to add the drop_count / max_level counters.
module linebuf_port_sched #(
  parameter int DATA_W     = 17,
  parameter int LINE_LEN   = 640,
  parameter int ADDR_W     = 11,
  parameter int LADDR_W    = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        pixclk,
  input  logic                        reset,
  input  logic                        wr_valid,
  output logic                        wr_ready,
  input  logic [LADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]           wr_data,
  input  logic                        wr_line_end,
  input  logic                        rd_valid,
  input  logic [LADDR_W-1:0]          rd_addr,
  input  logic                        rd_line_end,
  output logic [DATA_W-1:0]           rd_data,
  output logic                        rd_data_valid,
  output logic [ADDR_W-1:0]           ram_addr,
  output logic                        ram_we,
  output logic [DATA_W-1:0]           ram_wdata,
  input  logic [DATA_W-1:0]           ram_rdata,
  output logic                        wr_bank,
  output logic                        rd_bank,
  output logic                        rd_repeat,
  output logic                        overrun,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
`ifdef LINEBUF_STATS_EN
  ,
  output logic [15:0]                 drop_count,
  output logic [$clog2(FIFO_DEPTH):0] max_level
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam int EW = 1 + LADDR_W + DATA_W;
  localparam logic [LADDR_W:0]  LEN_L = (LADDR_W+1)'(LINE_LEN);
  localparam logic [ADDR_W-1:0] BASE1 = ADDR_W'(LINE_LEN);

  function automatic logic [ADDR_W-1:0] phys(
    input logic b, input logic [LADDR_W-1:0] a);
    return (b ? BASE1 : '0) + ADDR_W'(a);
  endfunction

  logic [EW-1:0]     mem_q [FIFO_DEPTH];
  logic [PW-1:0]     wptr_q, rptr_q;
  logic [LW-1:0]     cnt_q, cnt_d;
  logic              wr_acc, wr_in, rd_in, push, pop;
  logic [EW-1:0]     in_e, head;
  logic              h_bank;
  logic [LADDR_W-1:0] h_addr;
  logic [DATA_W-1:0] h_data;

  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic              ram_we_q, ram_we_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;

  logic              rv1_q, ok1_q, rv2_q, ok2_q, rdv_q;
  logic [DATA_W-1:0] rdd_q;

  logic              wr_bank_q, wr_done_q, wr_done_d;
  logic              rep_q, ovr_q;
  logic              swap, ovr_ev, rep_ev;

  assign wr_ready = (cnt_q != LW'(FIFO_DEPTH));
  assign wr_acc   = wr_valid && wr_ready;
  assign wr_in    = {1'b0, wr_addr} < LEN_L;
  assign rd_in    = {1'b0, rd_addr} < LEN_L;
  assign push     = wr_acc && wr_in;
  // An empty queue lets the incoming write go straight to the RAM.
  assign pop      = !rd_valid && ((cnt_q != '0) || push);
  assign cnt_d    = cnt_q + LW'(push) - LW'(pop);

  assign in_e   = {wr_bank_q, wr_addr, wr_data};
  assign head   = (cnt_q == '0) ? in_e : mem_q[rptr_q];
  assign h_bank = head[EW-1];
  assign h_addr = head[DATA_W +: LADDR_W];
  assign h_data = head[DATA_W-1:0];

  always_ff @(posedge pixclk) begin
    if (push) mem_q[wptr_q] <= in_e;
  end

  always_comb begin
    ram_addr_d  = ram_addr_q;
    ram_we_d    = 1'b0;
    ram_wdata_d = ram_wdata_q;
    if (rd_valid) begin
      if (rd_in) ram_addr_d = phys(~wr_bank_q, rd_addr);
    end else if (pop) begin
      ram_we_d    = 1'b1;
      ram_addr_d  = phys(h_bank, h_addr);
      ram_wdata_d = h_data;
    end
  end

  assign swap   = rd_line_end && (wr_done_q || wr_line_end);
  assign ovr_ev = wr_line_end && wr_done_q && !swap;
  assign rep_ev = rd_line_end && !wr_done_q && !wr_line_end;

  always_comb begin
    wr_done_d = wr_done_q;
    if (swap)             wr_done_d = 1'b0;
    else if (wr_line_end) wr_done_d = 1'b1;
  end

  always_ff @(posedge pixclk) begin
    if (reset) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      cnt_q       <= '0;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= '0;
      rv1_q       <= 1'b0;
      ok1_q       <= 1'b0;
      rv2_q       <= 1'b0;
      ok2_q       <= 1'b0;
      rdv_q       <= 1'b0;
      rdd_q       <= '0;
      wr_bank_q   <= 1'b0;
      wr_done_q   <= 1'b0;
      rep_q       <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      cnt_q       <= cnt_d;
      ram_addr_q  <= ram_addr_d;
      ram_we_q    <= ram_we_d;
      ram_wdata_q <= ram_wdata_d;
      rv1_q       <= rd_valid;
      ok1_q       <= rd_valid && rd_in;
      rv2_q       <= rv1_q;
      ok2_q       <= ok1_q;
      rdv_q       <= rv2_q;
      rdd_q       <= ok2_q ? ram_rdata : '0;
      if (swap) wr_bank_q <= ~wr_bank_q;
      wr_done_q   <= wr_done_d;
      rep_q       <= rep_ev;
      ovr_q       <= ovr_ev;
    end
  end

  assign ram_addr      = ram_addr_q;
  assign ram_we        = ram_we_q;
  assign ram_wdata     = ram_wdata_q;
  assign rd_data       = rdd_q;
  assign rd_data_valid = rdv_q;
  assign wr_bank       = wr_bank_q;
  assign rd_bank       = ~wr_bank_q;
  assign rd_repeat     = rep_q;
  assign overrun       = ovr_q;
  assign fifo_level    = cnt_q;

`ifdef LINEBUF_STATS_EN
  logic [15:0]   drop_q;
  logic [LW-1:0] max_q;
  logic [16:0]   drop_sum;

  assign drop_sum = {1'b0, drop_q} + 17'(wr_acc && !wr_in) + 17'(ovr_ev);

  always_ff @(posedge pixclk) begin
    if (reset) begin
      drop_q <= '0;
      max_q  <= '0;
    end else begin
      drop_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      if (cnt_d > max_q) max_q <= cnt_d;
    end
  end

  assign drop_count = drop_q;
  assign max_level  = max_q;
`endif

endmodule
